// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-side pointer controller for a dual-clock FIFO: binary/Gray write pointer,
// read-pointer synchronizer, write strobe/address, full, almost_full, occupancy, overflow.
module fifo_wr_ptr_ctrl #(
    parameter int ADDR_W   = 3,
    parameter int AFULL_TH = 6
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              wenable,
    input  logic [ADDR_W:0]   rptr_gray_async,
    output logic              wen_mem,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wcount,
    output logic              overflow
);

    localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W + 1)'(AFULL_TH);

    function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] wbin_nxt;
    logic [ADDR_W:0] wgray_nxt;
    logic [ADDR_W:0] rsync1;
    logic [ADDR_W:0] rsync2;
    logic [ADDR_W:0] rbin_sync;
    logic [ADDR_W:0] rgray_full;
    logic            accept;

    // Reset gates the strobe so no storage write can slip through while pointers are held at 0.
    assign accept    = wenable & ~full & n_rst;
    assign wen_mem   = accept;
    assign wbin_nxt  = wbin + {{ADDR_W{1'b0}}, accept};
    assign wgray_nxt = bin2gray(wbin_nxt);
    assign waddr     = wbin[ADDR_W-1:0];

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted, rest equal.
    assign rgray_full  = {~rsync2[ADDR_W:ADDR_W-1], rsync2[ADDR_W-2:0]};
    assign rbin_sync   = gray2bin(rsync2);
    assign wcount      = wbin - rbin_sync;
    assign almost_full = (wcount >= AFULL_LVL);

    // Only rsync2 is consumed; rsync1 absorbs metastability from the read domain.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rsync1 <= '0;
            rsync2 <= '0;
        end else begin
            // NOTE: non-blocking so rsync2 takes the pre-edge rsync1, forming a true 2-stage chain.
            rsync1 <= rptr_gray_async;
            rsync2 <= rsync1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wbin      <= '0;
            wptr_gray <= '0;
            full      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            wbin      <= wbin_nxt;
            wptr_gray <= wgray_nxt;
            full      <= (wgray_nxt == rgray_full);
            overflow  <= wenable & full;
        end
    end

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Self-checking bench for fifo_wr_ptr_ctrl (ADDR_W=3, AFULL_TH=6): occupancy-based model
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_fifo_wr_ptr_ctrl;

    logic       clk;
    logic       n_rst;
    logic       wenable;
    logic [3:0] rptr_gray_async;
    logic       wen_mem;
    logic [2:0] waddr;
    logic [3:0] wptr_gray;
    logic       full;
    logic       almost_full;
    logic [3:0] wcount;
    logic       overflow;

    int n_pass  = 0;
    int n_total = 0;
    int tb_rptr = 0;

    fifo_wr_ptr_ctrl #(.ADDR_W(3), .AFULL_TH(6)) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .wenable         (wenable),
        .rptr_gray_async (rptr_gray_async),
        .wen_mem         (wen_mem),
        .waddr           (waddr),
        .wptr_gray       (wptr_gray),
        .full            (full),
        .almost_full     (almost_full),
        .wcount          (wcount),
        .overflow        (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rptr_gray_async = 4'(tb_rptr ^ (tb_rptr >> 1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: pushes counted mod 16, read pointer seen after two write-domain edges,
    // full whenever the post-push occupancy reaches the depth of 8.
    int m_w, m_r1, m_r2;
    bit m_full, m_ovf;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_w = 0; m_r1 = 0; m_r2 = 0; m_full = 0; m_ovf = 0;
        end else begin
            int nw;
            bit acc;
            acc    = wenable && !m_full;
            nw     = (m_w + int'(acc)) % 16;
            m_ovf  = wenable && m_full;
            m_full = (((nw - m_r2) % 16 + 16) % 16) == 8;
            m_w    = nw;
            m_r2   = m_r1;
            m_r1   = tb_rptr % 16;
        end
    end

    logic [3:0] prev_gray = '0;

    always @(negedge clk) begin
        int occ;
        occ = ((m_w - m_r2) % 16 + 16) % 16;
        check("wen_mem",     wen_mem,     32'(n_rst && wenable && !m_full));
        check("waddr",       waddr,       32'(m_w % 8));
        check("wptr_gray",   wptr_gray,   32'(m_w ^ (m_w >> 1)));
        check("full",        full,        32'(m_full));
        check("overflow",    overflow,    32'(m_ovf));
        check("wcount",      wcount,      32'(occ));
        check("almost_full", almost_full, 32'(occ >= 6));
        if (!n_rst) begin
            prev_gray = '0;
        end else begin
            if (wptr_gray !== prev_gray) check("gray_hamming", $countones(wptr_gray ^ prev_gray), 1);
            prev_gray = wptr_gray;
        end
    end

    // Inputs are applied 1 time unit after a rising edge; the next edge then samples them.
    task automatic cyc(input bit we);
        wenable = we;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wenable = 1'b0;
        tb_rptr = 0;
        n_rst   = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst   = 1'b0;
        wenable = 1'b0;
        do_reset();

        // 1: reset asserted mid-cycle clears everything at once
        repeat (3) cyc(1'b1);
        #2;
        n_rst = 1'b0;
        #1;
        check("rst_wptr_gray", wptr_gray, 0);
        check("rst_waddr",     waddr,     0);
        check("rst_full",      full,      0);
        check("rst_overflow",  overflow,  0);
        check("rst_wcount",    wcount,    0);
        check("rst_wen_mem",   wen_mem,   0);
        do_reset();

        // 2: fill to full, then one rejected push
        for (int i = 0; i < 8; i++) begin
            wenable = 1'b1;
            #1;
            check("fill_waddr", waddr, 32'(i));
            check("fill_wen",   wen_mem, 1);
            cyc(1'b1);
        end
        check("fill_gray",   wptr_gray, 4'b1100);
        check("fill_full",   full, 1);
        check("fill_wcount", wcount, 8);
        #1;
        check("over_wen", wen_mem, 0);
        cyc(1'b1);
        check("over_pulse", overflow, 1);
        check("over_gray",  wptr_gray, 4'b1100);
        cyc(1'b0);
        check("over_drop", overflow, 0);

        // 3: read pointer advances by one; full drops on the 3rd edge
        tb_rptr = 1;
        cyc(1'b0);
        check("rel_full_e1", full, 1);
        cyc(1'b0);
        check("rel_full_e2", full, 1);
        cyc(1'b0);
        check("rel_full_e3",   full, 0);
        check("rel_wcount_e3", wcount, 7);
        wenable = 1'b1;
        #1;
        check("rel_push_wen",   wen_mem, 1);
        check("rel_push_waddr", waddr, 0);
        cyc(1'b1);
        check("rel_refull", full, 1);
        cyc(1'b0);

        // 4: wrap with read pointer trailing by two pushes
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tb_rptr = (i >= 2) ? (i - 2) % 16 : 0;
            cyc(1'b1);
            check("wrap_no_full", full, 0);
            if (i == 14) check("wrap_gray15", wptr_gray, 4'b1000);
            if (i == 15) check("wrap_gray0",  wptr_gray, 4'b0000);
        end
        cyc(1'b0);

        // 5: almost_full threshold at 6 entries
        do_reset();
        repeat (5) cyc(1'b1);
        check("af_5", almost_full, 0);
        check("af_5_wcount", wcount, 5);
        cyc(1'b1);
        check("af_6", almost_full, 1);
        check("af_6_wcount", wcount, 6);
        cyc(1'b0);

        // 6: reset mid-fill with wenable held high
        do_reset();
        repeat (5) cyc(1'b1);
        wenable = 1'b1;
        n_rst   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("mrst_wen",   wen_mem, 0);
            check("mrst_waddr", waddr, 0);
            check("mrst_gray",  wptr_gray, 0);
            check("mrst_count", wcount, 0);
            @(posedge clk); #1;
        end
        n_rst = 1'b1;
        #1;
        check("mrst_first_waddr", waddr, 0);
        check("mrst_first_wen",   wen_mem, 1);
        cyc(1'b1);
        check("mrst_second_waddr", waddr, 1);
        cyc(1'b0);
        cyc(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
